// File: rtl/core_pkg.sv
// Shared definitions for the fetch/decode boundary of the single-issue LEGv8 core:
// fetch FSM encoding, instruction and opcode widths, and opcode patterns.
package core_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_W   = 11;
  localparam int IMM19_W = 19;

  localparam logic [OPC_W-1:0] OP_HALT         = 11'b00000000000;
  // CBZ is identified by the top eight opcode bits only.
  localparam logic [7:0]       OPC_CBZ_PATTERN = 8'b10110100;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_HALT  = 3'd3,
    ST_ERROR = 3'd4
  } fetch_state_e;

  function automatic logic is_cbz(input logic [OPC_W-1:0] op);
    return op[OPC_W-1 -: 8] == OPC_CBZ_PATTERN;
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Next-PC candidates: sequential pc+4 and the CBZ target pc + (sext(imm19) << 2).
// Both wrap modulo 2^ADDR_W.
module branch_target_calc
  import core_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0]  pc,
  input  logic [IMM19_W-1:0] imm19,
  output logic [ADDR_W-1:0]  target,
  output logic [ADDR_W-1:0]  pc_plus4
);

  logic [ADDR_W-1:0] offset;

  assign offset   = {{(ADDR_W-IMM19_W-2){imm19[IMM19_W-1]}}, imm19, 2'b00};
  assign target   = pc + offset;
  assign pc_plus4 = pc + ADDR_W'(4);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests words from instruction memory, holds them in IR
// for decode, and advances or redirects the PC when decode accepts an instruction.
module instr_fetch_unit
  import core_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MAX_WAIT = 255
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [OPC_W-1:0]   operation,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  input  logic               branch,
  input  logic               zero,
  output logic               halted,
  output logic               fetch_error
);

  localparam int                CNT_W       = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST   = CNT_W'(MAX_WAIT - 1);
  localparam logic [ADDR_W-1:0] RESET_PC_AL = {RESET_PC[ADDR_W-1:2], 2'b00};

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  target, pc_plus4;

  branch_target_calc #(.ADDR_W(ADDR_W)) u_btc (
    .pc       (pc_q),
    .imm19    (ir_q[23:5]),
    .target   (target),
    .pc_plus4 (pc_plus4)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ISSUE: begin
        // branch/zero only matter on the accepting edge; pc stays put for a halt.
        if (instr_ready) begin
          if (ir_q == '0) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = (branch && zero) ? target : pc_plus4;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT, ST_ERROR: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC_AL;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == ST_ISSUE);
  assign operation   = ir_q[INSTR_W-1 -: OPC_W];
  assign instr       = ir_q;
  assign pc          = pc_q;
  assign halted      = (state_q == ST_HALT);
  assign fetch_error = (state_q == ST_ERROR);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a transaction-level model checked every
// cycle, plus directed scenarios with hand-computed addresses and opcodes.
module tb_instr_fetch_unit;
  import core_pkg::*;

  localparam int          ADDR_W   = 64;
  localparam int          MAX_WAIT = 8;
  localparam logic [31:0] NOP      = 32'h8B000000;
  localparam logic [63:0] TOP_PC   = 64'hFFFF_FFFF_FFFF_FFFC;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack = 1'b0;
  logic [31:0]       imem_rdata = '0;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic [10:0]       operation;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] pc;
  logic              branch = 1'b0;
  logic              zero = 1'b0;
  logic              halted;
  logic              fetch_error;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(64'h0), .MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .operation   (operation),
    .instr       (instr),
    .pc          (pc),
    .branch      (branch),
    .zero        (zero),
    .halted      (halted),
    .fetch_error (fetch_error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory; unwritten addresses read as a non-branch ADD.
  logic [31:0] mem [logic [63:0]];

  function automatic logic [31:0] mem_read(input logic [63:0] a);
    if (^a === 1'bx) return '0;
    if (mem.exists(a)) return mem[a];
    return NOP;
  endfunction

  // Memory/decode responder, acting 2 time units after the falling edge.
  int ack_delay = 0, ready_delay = 0, req_cnt = 0, vld_cnt = 0;
  bit mem_dead = 1'b0, force_ack = 1'b0;

  initial forever begin
    @(negedge clk);
    #2;
    if (imem_req) begin
      imem_ack = force_ack || (!mem_dead && req_cnt >= ack_delay);
      req_cnt++;
    end else begin
      imem_ack = force_ack;
      req_cnt  = 0;
    end
    imem_rdata = mem_read(imem_addr);
    if (instr_valid) begin
      instr_ready = (vld_cnt >= ready_delay);
      vld_cnt++;
    end else begin
      instr_ready = 1'b0;
      vld_cnt     = 0;
    end
  end

  // Behavioural model: what the unit is doing and which instruction/PC it holds.
  typedef enum {M_IDLE, M_FETCH, M_ISSUE, M_HALT, M_ERR} mode_e;
  mode_e       m_mode  = M_IDLE;
  logic [63:0] m_pc    = '0;
  logic [31:0] m_ir    = '0;
  int          m_wait  = 0;
  bit          m_known = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode  <= M_IDLE;
      m_pc    <= '0;
      m_ir    <= '0;
      m_wait  <= 0;
      m_known <= 1'b1;
    end else if (m_known) begin
      case (m_mode)
        M_IDLE:  m_mode <= M_FETCH;
        M_FETCH: begin
          if (imem_ack) begin
            m_ir   <= imem_rdata;
            m_wait <= 0;
            m_mode <= M_ISSUE;
          end else begin
            m_wait <= m_wait + 1;
            if (m_wait + 1 == MAX_WAIT) m_mode <= M_ERR;
          end
        end
        M_ISSUE: begin
          if (instr_ready) begin
            if (m_ir == 32'h0) m_mode <= M_HALT;
            else begin
              if (branch && zero)
                m_pc <= m_pc + 64'(longint'($signed(m_ir[23:5])) * 4);
              else
                m_pc <= m_pc + 64'd4;
              m_mode <= M_FETCH;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("imem_req",    imem_req,    m_mode == M_FETCH);
      check("imem_addr",   imem_addr,   m_pc);
      check("pc",          pc,          m_pc);
      check("instr_valid", instr_valid, m_mode == M_ISSUE);
      check("instr",       instr,       m_ir);
      check("operation",   operation,   m_ir[31:21]);
      check("halted",      halted,      m_mode == M_HALT);
      check("fetch_error", fetch_error, m_mode == M_ERR);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic fail_timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for the DUT at %0t", name, $time);
  endtask

  task automatic wait_issue_at(input logic [63:0] a, input int budget);
    int k = 0;
    while (!(instr_valid === 1'b1 && pc === a) && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) fail_timeout("wait_issue");
  endtask

  task automatic take_branch_at(input logic [63:0] a, input logic z);
    wait_issue_at(a, 40);
    branch = 1'b1;
    zero   = z;
    tick();
    branch = 1'b0;
    zero   = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    logic [63:0] addrs[$];
    logic [10:0] ops[$];
    logic [63:0] a0, p0;
    logic [31:0] i0;
    logic [10:0] o0;
    int vrun, maxrun, first_req, n, nv;
    bit stable;

    // Streaming with ack and ready tied high.
    mem.delete();
    mem[64'h0] = 32'hF8400000;
    mem[64'h4] = 32'h8B000000;
    do_reset();
    check("reset_req", imem_req, 1'b0);
    check("reset_pc", pc, 64'h0);
    check("reset_instr", instr, 32'h0);
    vrun = 0; maxrun = 0; first_req = -1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (imem_req) begin
        addrs.push_back(imem_addr);
        if (first_req < 0) first_req = c;
      end
      if (instr_valid) begin
        ops.push_back(operation);
        vrun++;
        if (vrun > maxrun) maxrun = vrun;
      end else vrun = 0;
    end
    check("first_req_cycle", first_req, 1);
    check("n_addrs", addrs.size(), 4);
    check("addr0", addrs[0], 64'h0);
    check("addr1", addrs[1], 64'h4);
    check("addr2", addrs[2], 64'h8);
    check("op0", ops[0], 11'h7C2);
    check("op1", ops[1], 11'h458);
    check("valid_pulse_len", maxrun, 1);

    // CBZ at 0x10 with imm19 = 3: taken, not taken, and imm19 = -1 taken.
    mem.delete();
    mem[64'h10] = {OPC_CBZ_PATTERN, 19'd3, 5'd0};
    do_reset();
    take_branch_at(64'h10, 1'b1);
    check("cbz_taken_req", imem_req, 1'b1);
    check("cbz_taken_addr", imem_addr, 64'h1C);
    do_reset();
    take_branch_at(64'h10, 1'b0);
    check("cbz_not_taken_addr", imem_addr, 64'h14);
    mem[64'h10] = {OPC_CBZ_PATTERN, 19'h7FFFF, 5'd0};
    do_reset();
    take_branch_at(64'h10, 1'b1);
    check("cbz_back_addr", imem_addr, 64'h0C);

    // Slow memory (ack after 5 waits) and slow decode (ready after 3 waits).
    mem.delete();
    ack_delay = 5; ready_delay = 3;
    do_reset();
    tick();
    a0 = imem_addr; n = 0; stable = 1'b1;
    while (imem_req && n < 20) begin
      if (imem_addr !== a0) stable = 1'b0;
      n++;
      tick();
    end
    check("req_hold_cycles", n, 6);
    check("req_addr_stable", stable, 1'b1);
    o0 = operation; i0 = instr; p0 = pc; nv = 0; stable = 1'b1;
    while (instr_valid && nv < 20) begin
      if (operation !== o0 || instr !== i0 || pc !== p0) stable = 1'b0;
      nv++;
      tick();
    end
    check("valid_hold_cycles", nv, 4);
    check("issue_stable", stable, 1'b1);
    check("pc_after_accept", pc, 64'h4);
    ack_delay = 0; ready_delay = 0;

    // Memory never answers.
    mem_dead = 1'b1;
    do_reset();
    tick();
    n = 0;
    while (imem_req && n < 20) begin
      n++;
      tick();
    end
    check("fetch_cycles_before_error", n, MAX_WAIT);
    check("fetch_error_set", fetch_error, 1'b1);
    repeat (6) tick();
    check("fetch_error_sticky", fetch_error, 1'b1);
    check("req_dropped", imem_req, 1'b0);
    mem_dead = 1'b0;
    do_reset();
    check("error_cleared", fetch_error, 1'b0);

    // All-zero instruction at 0x8 halts the unit.
    mem.delete();
    mem[64'h8] = 32'h0;
    do_reset();
    wait_issue_at(64'h8, 40);
    check("halt_op", operation, OP_HALT);
    tick();
    check("halted_set", halted, 1'b1);
    n = 0;
    repeat (10) begin
      tick();
      if (imem_req) n++;
    end
    check("no_req_after_halt", n, 0);
    check("halt_pc", pc, 64'h8);
    do_reset();
    tick();
    check("restart_req", imem_req, 1'b1);
    check("restart_addr", imem_addr, 64'h0);

    // Reset mid-fetch with an ack on the same edge, then an ack while idle.
    mem.delete();
    ack_delay = 3;
    do_reset();
    tick();
    force_ack = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_ack_instr", instr, 32'h0);
    check("rst_ack_valid", instr_valid, 1'b0);
    tick();
    force_ack = 1'b0;
    check("idle_ack_ignored_instr", instr, 32'h0);
    check("idle_ack_req", imem_req, 1'b1);
    check("idle_ack_addr", imem_addr, 64'h0);
    ack_delay = 0;

    // PC wraps: branch back from 0 to 2^64-4, then sequential step to 0.
    mem.delete();
    mem[64'h0] = {OPC_CBZ_PATTERN, 19'h7FFFF, 5'd0};
    do_reset();
    take_branch_at(64'h0, 1'b1);
    check("wrap_back_addr", imem_addr, TOP_PC);
    wait_issue_at(TOP_PC, 40);
    tick();
    check("wrap_req", imem_req, 1'b1);
    check("wrap_addr", imem_addr, 64'h0);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
